// File: rtl/ctrl_to_axilite.sv
// ctrl_to_axilite: bridges a single-outstanding valid/ready control port
// onto an AXI-Lite master; one read or write is in flight at a time.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_*_i / req_ready_o control-side request (word address, data, strobes)
//   resp_*_o / resp_ready_i completion (read data, error flag)
//   m_axilite_*           AXI-Lite master channels AW, W, B, AR, R
module ctrl_to_axilite #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [9:0]        req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              m_axilite_awvalid_o,
  input  logic              m_axilite_awready_i,
  output logic [ADDR_W-1:0] m_axilite_awaddr_o,
  output logic [2:0]        m_axilite_awprot_o,
  output logic              m_axilite_wvalid_o,
  input  logic              m_axilite_wready_i,
  output logic [31:0]       m_axilite_wdata_o,
  output logic [3:0]        m_axilite_wstrb_o,
  input  logic              m_axilite_bvalid_i,
  output logic              m_axilite_bready_o,
  input  logic [1:0]        m_axilite_bresp_i,
  output logic              m_axilite_arvalid_o,
  input  logic              m_axilite_arready_i,
  output logic [ADDR_W-1:0] m_axilite_araddr_o,
  output logic [2:0]        m_axilite_arprot_o,
  input  logic              m_axilite_rvalid_i,
  output logic              m_axilite_rready_o,
  input  logic [31:0]       m_axilite_rdata_i,
  input  logic [1:0]        m_axilite_rresp_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        awv, wv, bry, arv, rry;
  logic        aw_fin, w_fin;
  logic [ADDR_W-1:0] axaddr;

  // Byte address is the zero-extended word address.
  assign axaddr = ADDR_W'({addr_q, 2'b00});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awv       = 1'b0;
    wv        = 1'b0;
    bry       = 1'b0;
    arv       = 1'b0;
    rry       = 1'b0;
    aw_fin    = aw_done_q;
    w_fin     = w_done_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write_i ? S_WR : S_RA;
        end
      end
      S_WR: begin
        awv    = !aw_done_q;
        wv     = !w_done_q;
        aw_fin = aw_done_q | m_axilite_awready_i;
        w_fin  = w_done_q | m_axilite_wready_i;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        // Both channels may finish in either order or together.
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        bry = 1'b1;
        if (m_axilite_bvalid_i) begin
          err_d   = |m_axilite_bresp_i;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RA: begin
        arv = 1'b1;
        if (m_axilite_arready_i) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        rry = 1'b1;
        if (m_axilite_rvalid_i) begin
          err_d   = |m_axilite_rresp_i;
          rdata_d = m_axilite_rdata_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Outputs are forced low during reset, including the first reset
  // cycle before the state register has been cleared.
  assign req_ready_o         = !rst && (state_q == S_IDLE);
  assign resp_valid_o        = !rst && (state_q == S_RESP);
  assign resp_rdata_o        = rst ? '0 : rdata_q;
  assign resp_err_o          = !rst && err_q;

  assign m_axilite_awvalid_o = !rst && awv;
  assign m_axilite_awaddr_o  = axaddr;
  assign m_axilite_awprot_o  = 3'b000;
  assign m_axilite_wvalid_o  = !rst && wv;
  assign m_axilite_wdata_o   = wdata_q;
  assign m_axilite_wstrb_o   = wstrb_q;
  assign m_axilite_bready_o  = !rst && bry;
  assign m_axilite_arvalid_o = !rst && arv;
  assign m_axilite_araddr_o  = axaddr;
  assign m_axilite_arprot_o  = 3'b000;
  assign m_axilite_rready_o  = !rst && rry;

endmodule

// File: tb/tb_ctrl_to_axilite.sv
// tb_ctrl_to_axilite: table vectors, hand-written corner sequences and
// random transactions against a latency/data model of the bridge.
module tb_ctrl_to_axilite;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_tot = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ctrl_to_axilite #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_axilite_awvalid_o(awvalid), .m_axilite_awready_i(awready),
    .m_axilite_awaddr_o(awaddr), .m_axilite_awprot_o(awprot),
    .m_axilite_wvalid_o(wvalid), .m_axilite_wready_i(wready),
    .m_axilite_wdata_o(wdata), .m_axilite_wstrb_o(wstrb),
    .m_axilite_bvalid_i(bvalid), .m_axilite_bready_o(bready),
    .m_axilite_bresp_i(bresp),
    .m_axilite_arvalid_o(arvalid), .m_axilite_arready_i(arready),
    .m_axilite_araddr_o(araddr), .m_axilite_arprot_o(arprot),
    .m_axilite_rvalid_i(rvalid), .m_axilite_rready_o(rready),
    .m_axilite_rdata_i(rdata), .m_axilite_rresp_i(rresp)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_d, w_d, ar_d, b_d, r_d, rr_d;
    bit          noise;
    logic [11:0] e_addr;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
  } vec_t;

  typedef struct {
    bit          done;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          viol;
  } res_t;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic vec_t mk(logic wr, logic [9:0] a, logic [31:0] wd,
                              logic [3:0] ws, logic [31:0] rd,
                              logic [1:0] rsp, int awd, int wdl, int ard,
                              int bd, int rdl, int rrd, bit nz,
                              logic [11:0] ea, logic [31:0] er,
                              logic ee, int el);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.wstrb = ws;
    v.rdata = rd; v.resp = rsp;
    v.aw_d = awd; v.w_d = wdl; v.ar_d = ard;
    v.b_d = bd; v.r_d = rdl; v.rr_d = rrd; v.noise = nz;
    v.e_addr = ea; v.e_rdata = er; v.e_err = ee; v.e_lat = el;
    return v;
  endfunction

  // Expected results from the bridge's rules: byte address is word*4,
  // any non-OKAY response is an error, writes return zero data, and
  // latency is three cycles plus the slave's stall cycles.
  function automatic vec_t model(vec_t v);
    vec_t m = v;
    m.e_addr  = 12'(v.addr * 4);
    m.e_err   = (v.resp != 2'b00);
    m.e_rdata = v.wr ? 32'h0 : v.rdata;
    if (v.wr)
      m.e_lat = 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
    else
      m.e_lat = 3 + v.ar_d + v.r_d;
    return m;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = 0;
    req_wdata = 0; req_wstrb = 0; resp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
  endtask

  // Acts as requester and AXI-Lite slave, one step per falling edge.
  task automatic run_txn(input vec_t v, output res_t r);
    int cyc, awc, wc, arc, bc, rc, hold;
    bit aw_dn, w_dn, aw_p, w_p, ar_p, rs_seen, done;
    logic [11:0] aw_l, ar_l;
    logic [31:0] wd_l;
    logic [3:0]  ws_l;
    r.done = 0; r.lat = -1; r.err = 0; r.rdata = 0;
    r.addr = 0; r.wdata = 0; r.wstrb = 0; r.viol = 0;
    awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; hold = 0;
    aw_dn = 0; w_dn = 0; aw_p = 0; w_p = 0; ar_p = 0;
    rs_seen = 0; done = 0;
    aw_l = 0; ar_l = 0; wd_l = 0; ws_l = 0;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) r.viol++;
    req_valid = 1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 100) begin
      if (req_ready) r.viol++;
      if (aw_p && (!awvalid || awaddr !== aw_l)) r.viol++;
      if (w_p && (!wvalid || wdata !== wd_l || wstrb !== ws_l)) r.viol++;
      if (ar_p && (!arvalid || araddr !== ar_l)) r.viol++;
      if (aw_dn && awvalid) r.viol++;
      if (w_dn && wvalid) r.viol++;
      if (bready && !(aw_dn && w_dn)) r.viol++;
      if (bready && rready) r.viol++;
      if (awprot !== 3'b000 || arprot !== 3'b000) r.viol++;
      req_valid = v.noise && ($urandom_range(0, 1) == 1);
      req_write = 1'($urandom); req_addr = 10'($urandom);
      req_wdata = $urandom; req_wstrb = 4'($urandom);
      awready = v.noise && ($urandom_range(0, 1) == 1);
      wready  = v.noise && ($urandom_range(0, 1) == 1);
      arready = v.noise && ($urandom_range(0, 1) == 1);
      bvalid  = v.noise && ($urandom_range(0, 1) == 1);
      bresp   = 2'b11;
      rvalid  = v.noise && ($urandom_range(0, 1) == 1);
      rdata   = $urandom; rresp = 2'b11;
      resp_ready = 0;
      aw_p = 0; w_p = 0; ar_p = 0;
      if (awvalid) begin
        r.addr = awaddr; aw_l = awaddr;
        awready = (awc >= v.aw_d); awc++;
        if (awready) aw_dn = 1; else aw_p = 1;
      end
      if (wvalid) begin
        r.wdata = wdata; r.wstrb = wstrb;
        wd_l = wdata; ws_l = wstrb;
        wready = (wc >= v.w_d); wc++;
        if (wready) w_dn = 1; else w_p = 1;
      end
      if (bready) begin
        bvalid = (bc >= v.b_d); bresp = v.resp; bc++;
      end
      if (arvalid) begin
        r.addr = araddr; ar_l = araddr;
        arready = (arc >= v.ar_d); arc++;
        if (!arready) ar_p = 1;
      end
      if (rready) begin
        rvalid = (rc >= v.r_d); rdata = v.rdata; rresp = v.resp; rc++;
      end
      if (resp_valid) begin
        if (!rs_seen) begin
          rs_seen = 1; r.lat = cyc;
          r.err = resp_err; r.rdata = resp_rdata;
        end else if (resp_err !== r.err || resp_rdata !== r.rdata) begin
          r.viol++;
        end
        resp_ready = (hold >= v.rr_d); hold++;
        if (resp_ready) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    r.done = done;
    if (done && (resp_valid || !req_ready)) r.viol++;
    idle_inputs();
  endtask

  task automatic check_res(string tag, vec_t v, res_t r);
    chk({tag, "_done"}, 64'(r.done), 64'd1);
    chk({tag, "_addr"}, 64'(r.addr), 64'(v.e_addr));
    chk({tag, "_err"}, 64'(r.err), 64'(v.e_err));
    chk({tag, "_rdata"}, 64'(r.rdata), 64'(v.e_rdata));
    chk({tag, "_lat"}, 64'(r.lat), 64'(v.e_lat));
    chk({tag, "_proto"}, 64'(r.viol), 64'd0);
    if (v.wr) begin
      chk({tag, "_wdata"}, 64'(r.wdata), 64'(v.wdata));
      chk({tag, "_wstrb"}, 64'(r.wstrb), 64'(v.wstrb));
    end
  endtask

  vec_t tbl[9];
  vec_t rv;
  res_t res;
  bit   seen;

  initial begin
    tbl[0] = mk(0, 10'h005, 0, 0, 32'hDEADBEEF, 2'b00,
                0, 0, 0, 0, 0, 0, 0, 12'h014, 32'hDEADBEEF, 0, 3);
    tbl[1] = mk(1, 10'h3FF, 32'h12345678, 4'b0101, 0, 2'b00,
                0, 3, 0, 0, 0, 0, 0, 12'hFFC, 32'h0, 0, 6);
    tbl[2] = mk(1, 10'h010, 32'hA5A5A5A5, 4'hF, 32'hFFFF0000, 2'b10,
                0, 0, 0, 0, 0, 0, 0, 12'h040, 32'h0, 1, 3);
    tbl[3] = mk(0, 10'h2AB, 0, 0, 32'h0BADF00D, 2'b11,
                0, 0, 0, 0, 0, 0, 0, 12'hAAC, 32'h0BADF00D, 1, 3);
    tbl[4] = mk(0, 10'h001, 0, 0, 32'hCAFEF00D, 2'b00,
                0, 0, 0, 0, 0, 5, 1, 12'h004, 32'hCAFEF00D, 0, 3);
    tbl[5] = mk(0, 10'h123, 0, 0, 32'h11223344, 2'b00,
                0, 0, 0, 0, 0, 0, 0, 12'h48C, 32'h11223344, 0, 3);
    tbl[6] = mk(1, 10'h0AA, 32'h55AA55AA, 4'b1000, 0, 2'b00,
                0, 0, 0, 0, 0, 0, 0, 12'h2A8, 32'h0, 0, 3);
    tbl[7] = mk(1, 10'h200, 32'h0, 4'b0011, 0, 2'b01,
                2, 0, 0, 2, 0, 1, 0, 12'h800, 32'h0, 1, 7);
    tbl[8] = mk(0, 10'h07F, 0, 0, 32'hFFFFFFFF, 2'b00,
                0, 0, 1, 0, 2, 0, 0, 12'h1FC, 32'hFFFFFFFF, 0, 6);

    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_valids",
        64'({awvalid, wvalid, bready, arvalid, rready, resp_valid}), 0);
    chk("rst_err", 64'(resp_err), 0);
    chk("rst_rdata", 64'(resp_rdata), 0);
    rst = 0;
    @(negedge clk);
    chk("rel_req_ready", 64'(req_ready), 1);

    // Stray B and R responses while idle change nothing.
    bvalid = 1; bresp = 2'b10; rvalid = 1; rresp = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("stray_state", 64'({req_ready, resp_valid, bready, rready}),
        64'b1000);
    idle_inputs();

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i], res);
      check_res($sformatf("tbl%0d", i), tbl[i], res);
    end

    // Reset while waiting for B abandons the write.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 10'h155;
    req_wdata = 32'h01020304; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 0; awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    chk("wb_bready", 64'(bready), 1);
    rst = 1;
    @(negedge clk);
    chk("wbrst_outs",
        64'({awvalid, wvalid, bready, arvalid, rready, resp_valid}), 0);
    rst = 0;
    @(negedge clk);
    chk("wbrst_ready", 64'(req_ready), 1);
    seen = 0;
    bvalid = 1; bresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) seen = 1;
    end
    chk("wbrst_noresp", 64'(seen), 0);
    idle_inputs();

    for (int i = 0; i < 40; i++) begin
      rv.wr = 1'($urandom);
      rv.addr = 10'($urandom);
      rv.wdata = $urandom;
      rv.wstrb = 4'($urandom);
      rv.rdata = $urandom;
      rv.resp = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom);
      rv.aw_d = $urandom_range(0, 3);
      rv.w_d = $urandom_range(0, 3);
      rv.ar_d = $urandom_range(0, 3);
      rv.b_d = $urandom_range(0, 3);
      rv.r_d = $urandom_range(0, 3);
      rv.rr_d = $urandom_range(0, 3);
      rv.noise = 1'($urandom);
      rv = model(rv);
      run_txn(rv, res);
      check_res($sformatf("rnd%0d", i), rv, res);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
